// File: rtl/operand_loader_if.sv
// ---------------------------------------------------------------------------
// operand_loader_if
// Bundle between the board-side operand loader and its surrounding logic.
//
//   sw        8  switch value to be captured as an operand
//   btn_load  1  raw push-button, active-high, asynchronous, bouncy
//   A         8  registered operand A for the ALU
//   B         8  registered operand B for the ALU
//   valid     1  A and B both loaded and stable
//   state     2  loader FSM state for LEDs (00 WAIT_A, 01 WAIT_B, 10 READY)
//
// Handshake semantics: there is no back-pressure. valid is a level, not a
// pulse: while valid=1, A and B are guaranteed not to change, so the
// consumer may use them on any cycle. valid rises on the edge that loads B
// and falls on the edge that loads a new A.
// ---------------------------------------------------------------------------
interface operand_loader_if;
    logic [7:0] sw;
    logic       btn_load;
    logic [7:0] A;
    logic [7:0] B;
    logic       valid;
    logic [1:0] state;

    // master: board/test side driving switches and button, observing operands
    modport master (
        output sw,
        output btn_load,
        input  A,
        input  B,
        input  valid,
        input  state
    );

    // slave: the operand loader itself
    modport slave (
        input  sw,
        input  btn_load,
        output A,
        output B,
        output valid,
        output state
    );
endinterface

// File: rtl/operand_loader.sv
// ---------------------------------------------------------------------------
// operand_loader
// Captures operands A and B from the 8 board switches on two successive
// presses of one push-button and presents them, with a valid flag, to the
// bitwise operation blocks. The raw button is synchronised, debounced and
// edge-detected so each accepted press advances the loader exactly once.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous, active-high reset
//   bus    operand_loader_if.slave: sw, btn_load in; A, B, valid, state out
//
// Parameter:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new button
//                    level (must be >= 1)
// ---------------------------------------------------------------------------
module operand_loader #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    operand_loader_if.slave  bus
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } state_t;

    // -----------------------------------------------------------------------
    // Button synchroniser, debouncer and press-edge detector
    // -----------------------------------------------------------------------
    logic          s1_q;
    logic          s2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press;

    // The count only runs while the synchronised level disagrees with the
    // accepted level; any return to the accepted level restarts it, so the
    // counter can never pass CNT_LAST.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        if (s2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_d = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_q       <= bus.btn_load;
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
        end
    end

    // One-cycle pulse on the accepted rising level only; releases are ignored.
    assign press = deb_q & ~deb_prev_q;

    // -----------------------------------------------------------------------
    // Operand FSM
    // -----------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [7:0] a_q;
    logic [7:0] a_d;
    logic [7:0] b_q;
    logic [7:0] b_d;
    logic       valid_q;
    logic       valid_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        valid_d = valid_q;
        case (state_q)
            WAIT_A: begin
                if (press) begin
                    a_d     = bus.sw;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press) begin
                    b_d     = bus.sw;
                    valid_d = 1'b1;
                    state_d = READY;
                end
            end
            READY: begin
                // A new A invalidates the pair on the same edge it lands.
                if (press) begin
                    a_d     = bus.sw;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
            end
            default: begin
                // Unused encoding 11: recover without touching the operands.
                state_d = WAIT_A;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.valid = valid_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

    localparam int DEB = 4;

    logic clk = 1'b0;
    logic reset;

    operand_loader_if bus ();

    operand_loader #(
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: button level delayed two edges, accepted after DEB
    // consecutive differing observations; each accepted rise loads the next
    // operand in the order A, B, A, B, ... one edge later.
    logic       m_s1 = 1'b0;
    logic       m_s2 = 1'b0;
    logic       m_deb = 1'b0;
    logic       m_pend = 1'b0;
    int         m_run = 0;
    int         m_loads = 0;   // operands captured since reset
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_state();
        if (m_loads == 0) return 2'b00;
        return (m_loads % 2 == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic model_edge(input logic r, input logic b, input logic [7:0] s);
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_deb = 1'b0; m_pend = 1'b0;
            m_run = 0; m_loads = 0; m_a = 8'h00; m_b = 8'h00;
        end else begin
            if (m_pend) begin
                // Odd-numbered loads fill A, even-numbered fill B.
                if (m_loads % 2 == 0) m_a = s;
                else                  m_b = s;
                m_loads++;
                m_pend = 1'b0;
            end
            if (m_s2 != m_deb) begin
                m_run++;
                if (m_run == DEB) begin
                    m_deb = m_s2;
                    m_run = 0;
                    if (m_deb) m_pend = 1'b1;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic tick();
        logic       r;
        logic       b;
        logic [7:0] s;
        @(posedge clk);
        r = reset;
        b = bus.btn_load;
        s = bus.sw;
        model_edge(r, b, s);
        #1;
        check("model_A",     {24'h0, bus.A},     {24'h0, m_a});
        check("model_B",     {24'h0, bus.B},     {24'h0, m_b});
        check("model_valid", {31'h0, bus.valid}, {31'h0, (m_state() == 2'b10)});
        check("model_state", {30'h0, bus.state}, {30'h0, m_state()});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int         kind;
        int         nb;
        int         changes;
        logic [1:0] prev_state;

        reset        = 1'b1;
        bus.sw       = 8'hFF;
        bus.btn_load = 1'b1;

        // Reset with switches and button active: nothing captured.
        ticks(2);
        check("rst_A",     {24'h0, bus.A},     32'h00);
        check("rst_B",     {24'h0, bus.B},     32'h00);
        check("rst_valid", {31'h0, bus.valid}, 32'h0);
        check("rst_state", {30'h0, bus.state}, 32'h0);
        reset        = 1'b0;
        bus.btn_load = 1'b0;
        ticks(8);
        check("post_rst_state", {30'h0, bus.state}, 32'h0);

        // Load A=A5 with a clean press: lands on edge 7, not 6.
        bus.sw       = 8'hA5;
        bus.btn_load = 1'b1;
        ticks(6);
        check("lat6_state", {30'h0, bus.state}, 32'h0);
        check("lat6_A",     {24'h0, bus.A},     32'h00);
        tick();
        check("lat7_A",     {24'h0, bus.A},     32'hA5);
        check("lat7_state", {30'h0, bus.state}, 32'h1);
        check("lat7_valid", {31'h0, bus.valid}, 32'h0);
        bus.btn_load = 1'b0;
        bus.sw       = 8'h3C;
        ticks(10);

        // Load B=3C.
        bus.btn_load = 1'b1;
        ticks(7);
        check("ldB_B",     {24'h0, bus.B},         32'h3C);
        check("ldB_A",     {24'h0, bus.A},         32'hA5);
        check("ldB_valid", {31'h0, bus.valid},     32'h1);
        check("ldB_state", {30'h0, bus.state},     32'h2);
        check("ldB_xor",   {24'h0, bus.A ^ bus.B}, 32'h99);
        bus.btn_load = 1'b0;
        ticks(10);

        // Reload from READY: new A, valid drops, B holds.
        bus.sw       = 8'h0F;
        bus.btn_load = 1'b1;
        ticks(7);
        check("rel_A",     {24'h0, bus.A},     32'h0F);
        check("rel_B",     {24'h0, bus.B},     32'h3C);
        check("rel_valid", {31'h0, bus.valid}, 32'h0);
        check("rel_state", {30'h0, bus.state}, 32'h1);
        bus.btn_load = 1'b0;
        ticks(10);

        // Bouncy press then long hold: exactly one state change.
        bus.sw     = 8'h77;
        changes    = 0;
        prev_state = bus.state;
        for (int i = 0; i < 4; i++) begin
            bus.btn_load = (i % 2 == 0);
            tick();
            if (bus.state != prev_state) changes++;
            prev_state = bus.state;
        end
        bus.btn_load = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.state != prev_state) changes++;
            prev_state = bus.state;
        end
        check("bounce_changes", changes,                1);
        check("bounce_B",       {24'h0, bus.B},         32'h77);
        check("bounce_state",   {30'h0, bus.state},     32'h2);
        // Bounce on release produces nothing.
        for (int i = 0; i < 5; i++) begin
            bus.btn_load = (i % 2 == 1);
            tick();
        end
        bus.btn_load = 1'b0;
        ticks(12);
        check("release_state", {30'h0, bus.state}, 32'h2);

        // Short glitch never accepted.
        bus.sw       = 8'hE1;
        bus.btn_load = 1'b1;
        ticks(3);
        bus.btn_load = 1'b0;
        ticks(10);
        check("glitch_state", {30'h0, bus.state}, 32'h2);
        check("glitch_A",     {24'h0, bus.A},     32'h0F);
        check("glitch_B",     {24'h0, bus.B},     32'h77);

        // Reset mid-debounce in WAIT_B with the button held through reset.
        bus.sw       = 8'h11;
        bus.btn_load = 1'b1;
        ticks(7);
        check("pre6_state", {30'h0, bus.state}, 32'h1);
        bus.btn_load = 1'b0;
        ticks(10);
        bus.sw       = 8'h22;
        bus.btn_load = 1'b1;
        ticks(4);
        reset = 1'b1;
        tick();
        check("mid_rst_A",     {24'h0, bus.A},     32'h00);
        check("mid_rst_B",     {24'h0, bus.B},     32'h00);
        check("mid_rst_state", {30'h0, bus.state}, 32'h0);
        reset = 1'b0;
        ticks(6);
        check("held6_state", {30'h0, bus.state}, 32'h0);
        tick();
        check("held7_state", {30'h0, bus.state}, 32'h1);
        check("held7_A",     {24'h0, bus.A},     32'h22);
        bus.btn_load = 1'b0;
        ticks(10);

        // Randomised presses, bounces, glitches, switch churn and resets.
        for (int it = 0; it < 40; it++) begin
            bus.sw = 8'($urandom);
            kind   = $urandom_range(0, 9);
            if (kind == 0) begin
                reset = 1'b1;
                bus.btn_load = 1'($urandom);
                ticks($urandom_range(1, 2));
                reset = 1'b0;
            end else if (kind <= 2) begin
                bus.btn_load = 1'b1;
                ticks($urandom_range(1, DEB - 1));
                bus.btn_load = 1'b0;
            end else begin
                nb = $urandom_range(0, 3);
                for (int i = 0; i < nb; i++) begin
                    bus.btn_load = ~bus.btn_load;
                    tick();
                end
                bus.btn_load = 1'b1;
                for (int i = 0; i < $urandom_range(DEB, 15); i++) begin
                    bus.sw = 8'($urandom);
                    tick();
                end
                nb = $urandom_range(0, 3);
                for (int i = 0; i < nb; i++) begin
                    bus.btn_load = ~bus.btn_load;
                    tick();
                end
                bus.btn_load = 1'b0;
            end
            for (int i = 0; i < $urandom_range(0, 10); i++) begin
                bus.sw = 8'($urandom);
                tick();
            end
        end
        ticks(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
